// File: rtl/pe_mac_vec.sv
// Multi-lane signed multiply-accumulate PE: LANES products per term, registered adder
// tree, windowed accumulation closed by `last`, one saturating result per window.
module pe_mac_vec #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int SAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      last,
  input  logic                      clear,
  input  logic [LANES*DATA_W-1:0]   weight_i,
  input  logic [LANES*DATA_W-1:0]   pixel_i,
  output logic                      out_valid,
  output logic signed [ACC_W-1:0]   result_o,
  output logic                      sat_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  function automatic logic signed [PROD_W-1:0] mul_f(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [PROD_W-1:0] ax;
    logic signed [PROD_W-1:0] bx;
    ax = PROD_W'(a);
    bx = PROD_W'(b);
    return ax * bx;
  endfunction

  function automatic logic ovf_f(input logic signed [ACC_W:0] raw);
    return raw[ACC_W] ^ raw[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_f(input logic signed [ACC_W:0] raw);
    if (ovf_f(raw))
      return raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return raw[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] wrap_f(input logic signed [ACC_W:0] raw);
    return raw[ACC_W-1:0];
  endfunction

  // S1: per-lane exact products
  logic signed [PROD_W-1:0] prod_p1 [LANES];
  logic                     vld_p1;
  logic                     last_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      for (int k = 0; k < LANES; k++) prod_p1[k] <= '0;
    end else begin
      vld_p1  <= in_valid & ~clear;
      last_p1 <= last;
      for (int k = 0; k < LANES; k++)
        prod_p1[k] <= mul_f(weight_i[k*DATA_W +: DATA_W], pixel_i[k*DATA_W +: DATA_W]);
    end
  end

  // S2: adder tree, wide enough that the lane sum is exact
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] sum_p2;
  logic                    vld_p2;
  logic                    last_p2;

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < LANES; k++) sum_c = sum_c + SUM_W'(prod_p1[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p2  <= '0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      sum_p2  <= sum_c;
      vld_p2  <= vld_p1 & ~clear;
      last_p2 <= last_p1;
    end
  end

  // S3: window accumulator; open_p3=0 means the next valid term starts a window
  logic signed [ACC_W-1:0] acc_p3;
  logic                    stk_p3;
  logic                    open_p3;
  logic                    done_p3;
  logic signed [ACC_W-1:0] res_p3;
  logic                    rsat_p3;
  logic signed [ACC_W-1:0] base_c;
  logic signed [ACC_W:0]   raw_c;
  logic signed [ACC_W-1:0] nxt_c;
  logic                    ovf_c;

  always_comb begin
    base_c = open_p3 ? acc_p3 : '0;
    raw_c  = (ACC_W+1)'(base_c) + (ACC_W+1)'(sum_p2);
    ovf_c  = ovf_f(raw_c);
    nxt_c  = (SAT != 0) ? sat_f(raw_c) : wrap_f(raw_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p3  <= '0;
      stk_p3  <= 1'b0;
      open_p3 <= 1'b0;
      done_p3 <= 1'b0;
      res_p3  <= '0;
      rsat_p3 <= 1'b0;
    end else if (clear) begin
      acc_p3  <= '0;
      stk_p3  <= 1'b0;
      open_p3 <= 1'b0;
      done_p3 <= 1'b0;
    end else begin
      done_p3 <= vld_p2 & last_p2;
      if (vld_p2) begin
        if (last_p2) begin
          acc_p3  <= '0;
          stk_p3  <= 1'b0;
          open_p3 <= 1'b0;
          res_p3  <= nxt_c;
          rsat_p3 <= stk_p3 | ovf_c;
        end else begin
          acc_p3  <= nxt_c;
          stk_p3  <= stk_p3 | ovf_c;
          open_p3 <= 1'b1;
        end
      end
    end
  end

  // Output register: results are held between strobes and survive clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result_o  <= '0;
      sat_o     <= 1'b0;
    end else begin
      out_valid <= done_p3 & ~clear;
      if (done_p3 & ~clear) begin
        result_o <= res_p3;
        sat_o    <= rsat_p3;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_vec.sv
// Bench for pe_mac_vec: three instances (32-bit saturating, 17-bit saturating, 17-bit
// wrapping) share stimulus and are checked every cycle against a window-level model.
module tb_pe_mac_vec;
  localparam int DW = 8;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic last = 1'b0;
  logic clear = 1'b0;
  logic [LN*DW-1:0] weight_i = '0;
  logic [LN*DW-1:0] pixel_i = '0;

  logic ov0, ov1, ov2;
  logic s0, s1, s2;
  logic signed [31:0] res0;
  logic signed [16:0] res1, res2;

  always #5 clk = ~clk;

  pe_mac_vec #(.DATA_W(DW), .LANES(LN), .ACC_W(32), .SAT(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .last(last), .clear(clear),
    .weight_i(weight_i), .pixel_i(pixel_i), .out_valid(ov0), .result_o(res0), .sat_o(s0));
  pe_mac_vec #(.DATA_W(DW), .LANES(LN), .ACC_W(17), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .last(last), .clear(clear),
    .weight_i(weight_i), .pixel_i(pixel_i), .out_valid(ov1), .result_o(res1), .sat_o(s1));
  pe_mac_vec #(.DATA_W(DW), .LANES(LN), .ACC_W(17), .SAT(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .last(last), .clear(clear),
    .weight_i(weight_i), .pixel_i(pixel_i), .out_valid(ov2), .result_o(res2), .sat_o(s2));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Window-level model: a finished window's result is due 3 edges after its last term
  typedef struct packed {
    longint          due;
    logic [2:0][63:0] r;
    logic [2:0]       t;
  } ent_t;

  int     aw [3] = '{32, 17, 17};
  bit     sm [3] = '{1'b1, 1'b1, 1'b0};
  longint acc [3] = '{0, 0, 0};
  bit     stk [3] = '{0, 0, 0};
  bit     open_w = 1'b0;
  longint exp_res [3] = '{0, 0, 0};
  bit     exp_sat [3] = '{0, 0, 0};
  bit     exp_ov = 1'b0;
  longint cyc = 0;
  ent_t   q[$];

  function automatic void step(input longint base, input longint sum, input int w, input bit sat,
                               output longint nxt, output bit ovf);
    longint mx, mn, raw, mask;
    mx   = (longint'(1) <<< (w - 1)) - 1;
    mn   = -(longint'(1) <<< (w - 1));
    raw  = base + sum;
    ovf  = (raw > mx) || (raw < mn);
    if (!ovf) nxt = raw;
    else if (sat) nxt = (raw > mx) ? mx : mn;
    else begin
      mask = (longint'(1) <<< w) - 1;
      nxt  = raw & mask;
      if (nxt > mx) nxt = nxt - (longint'(1) <<< w);
    end
  endfunction

  initial begin : model
    longint sum, nxt;
    bit     ovf;
    ent_t   e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        open_w = 1'b0;
        exp_ov = 1'b0;
        for (int d = 0; d < 3; d++) begin
          acc[d] = 0; stk[d] = 1'b0; exp_res[d] = 0; exp_sat[d] = 1'b0;
        end
      end else begin
        cyc++;
        if (clear) begin
          while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
          open_w = 1'b0;
          for (int d = 0; d < 3; d++) begin acc[d] = 0; stk[d] = 1'b0; end
        end else if (in_valid) begin
          sum = 0;
          for (int k = 0; k < LN; k++)
            sum += longint'($signed(weight_i[k*DW +: DW])) * longint'($signed(pixel_i[k*DW +: DW]));
          e = '0;
          for (int d = 0; d < 3; d++) begin
            step(open_w ? acc[d] : 0, sum, aw[d], sm[d], nxt, ovf);
            acc[d] = nxt;
            stk[d] = (open_w ? stk[d] : 1'b0) | ovf;
            e.r[d] = nxt;
            e.t[d] = stk[d];
          end
          if (last) begin
            e.due = cyc + 3;
            q.push_back(e);
            open_w = 1'b0;
          end else begin
            open_w = 1'b1;
          end
        end
        exp_ov = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          exp_ov = 1'b1;
          for (int d = 0; d < 3; d++) begin
            exp_res[d] = $signed(e.r[d]);
            exp_sat[d] = e.t[d];
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("ov0", longint'(ov0), longint'(exp_ov));
      chk("ov1", longint'(ov1), longint'(exp_ov));
      chk("ov2", longint'(ov2), longint'(exp_ov));
      chk("res0", longint'(res0), exp_res[0]);
      chk("res1", longint'(res1), exp_res[1]);
      chk("res2", longint'(res2), exp_res[2]);
      chk("sat0", longint'(s0), longint'(exp_sat[0]));
      chk("sat1", longint'(s1), longint'(exp_sat[1]));
      chk("sat2", longint'(s2), longint'(exp_sat[2]));
    end
  end

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic term(input logic [31:0] w, input logic [31:0] p, input logic l, input logic c);
    in_valid = 1'b1; last = l; clear = c; weight_i = w; pixel_i = p;
    @(posedge clk); #1;
    in_valid = 1'b0; last = 1'b0; clear = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  longint b2b [4] = '{1, -2, 3, -4};

  initial begin : drive
    logic [31:0] m;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);
    chk("idle_ov", longint'(ov0), 0);

    term(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b0);
    term(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b0);
    term(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1, 1'b0);
    idle(2);
    chk("basic_early_ov", longint'(ov0), 0);
    idle(1);
    chk("basic_ov", longint'(ov0), 1);
    chk("basic_res", longint'(res0), 210);
    chk("basic_sat", longint'(s0), 0);

    #2 rst = 1'b1;
    #1;
    chk("arst_ov", longint'(ov0), 0);
    chk("arst_res", longint'(res0), 0);
    chk("arst_sat", longint'(s0), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    idle(10);

    term(pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b0, 1'b0);
    idle(2);
    term(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b1, 1'b0);
    idle(3);
    chk("sign_ov", longint'(ov0), 1);
    chk("sign_res", longint'(res0), 512);
    chk("sign_res17", longint'(res1), 512);
    chk("sign_sat17", longint'(s1), 0);

    for (int i = 0; i < 4; i++)
      term(pk(1, 0, 0, 0), pk(int'(b2b[i]), 0, 0, 0), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ov", longint'(ov0), 1);
      chk("b2b_res", longint'(res0), b2b[i]);
      idle(1);
    end

    m = pk(-128, -128, -128, -128);
    term(m, m, 1'b0, 1'b0);
    term(m, m, 1'b1, 1'b0);
    idle(3);
    chk("satw_res", longint'(res1), 65535);
    chk("satw_sat", longint'(s1), 1);
    // two terms of 2^16 wrap to exactly 0 in 17 bits
    chk("wrapw_res", longint'(res2), 0);
    chk("wrapw_sat", longint'(s2), 1);
    chk("wide_res", longint'(res0), 131072);
    chk("wide_sat", longint'(s0), 0);
    term(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b0);
    idle(3);
    chk("after_sat_res", longint'(res1), 1);
    chk("after_sat_sat", longint'(s1), 0);
    chk("after_wrap_sat", longint'(s2), 0);

    term(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b0);
    term(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b0);
    clr();
    term(pk(7, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b0);
    idle(3);
    chk("clear_ov", longint'(ov0), 1);
    chk("clear_res", longint'(res0), 7);
    term(pk(3, 0, 0, 0), pk(3, 0, 0, 0), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("clear_last_ov", longint'(ov0), 0);
    end
    chk("clear_hold_res", longint'(res0), 7);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      in_valid = ($urandom_range(0, 9) < 7);
      last     = ($urandom_range(0, 3) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) begin
        weight_i = pk(-128, -128, -128, -128);
        pixel_i  = ($urandom_range(0, 1) == 0) ? pk(-128, -128, -128, -128) : pk(127, 127, 127, 127);
      end else begin
        weight_i = $urandom;
        pixel_i  = $urandom;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; last = 1'b0; clear = 1'b0;
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
